// File: rtl/fretboard_sequencer.sv
// Beat-windowed record/playback engine: folds string/fret activity of each beat
// into a one-hot-per-string note word, stores it, and replays it at the beat rate.
module fretboard_sequencer #(
  parameter int NUM_STRINGS = 6,
  parameter int NUM_FRETS   = 4,
  parameter int DEPTH       = 64,
  parameter int CNT_W       = 27,
  localparam int NOTE_W     = NUM_STRINGS * (NUM_FRETS + 1),
  localparam int AW         = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   rec_start,
  input  logic                   play_start,
  input  logic                   stop,
  input  logic                   loop,
  input  logic [CNT_W-1:0]       beat_period,
  input  logic [NUM_STRINGS-1:0] strings,
  input  logic [NUM_FRETS-1:0]   frets,
  output logic [NOTE_W-1:0]      note_out,
  output logic                   note_valid,
  output logic                   beat_tick,
  output logic [1:0]             state,
  output logic [AW:0]            rec_len,
  output logic                   full
);

  localparam int FW = $clog2(NUM_FRETS + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RECORD = 2'd1,
    PLAY   = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, period_m1;
  logic                   tick;
  logic [AW-1:0]          addr_q;
  logic [AW:0]            rec_len_q;
  logic                   full_q;
  logic [NUM_STRINGS-1:0] str_acc_q, str_acc_d;
  logic [FW-1:0]          fret_acc_q, fret_acc_d, fret_cur;
  logic [NOTE_W-1:0]      note_word;
  logic [NOTE_W-1:0]      mem [DEPTH];
  logic                   at_top, at_last;
  logic                   enter_rec, enter_play, do_write, do_emit;

  // Periods below 2 would leave no room for the reload cycle.
  assign period_m1 = (beat_period < CNT_W'(2)) ? CNT_W'(1) : beat_period - CNT_W'(1);
  assign tick      = (state_q != IDLE) && (cnt_q == '0);
  assign at_top    = (addr_q == AW'(DEPTH - 1));
  assign at_last   = ({1'b0, addr_q} == rec_len_q - (AW+1)'(1));

  always_comb begin
    fret_cur = '0;
    for (int f = 1; f <= NUM_FRETS; f++) begin
      if (frets[f-1]) fret_cur = FW'(f);
    end
  end

  // The tick cycle's own inputs are folded in before encoding.
  always_comb begin
    str_acc_d  = str_acc_q | strings;
    fret_acc_d = fret_acc_q;
    if ((strings != '0) && (fret_cur > fret_acc_q)) fret_acc_d = fret_cur;
    note_word = '0;
    for (int f = 0; f <= NUM_FRETS; f++) begin
      if (fret_acc_d == FW'(f)) note_word[f*NUM_STRINGS +: NUM_STRINGS] = str_acc_d;
    end
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (enter_rec)       state_d = RECORD;
        else if (enter_play) state_d = PLAY;
      end
      RECORD: begin
        if (stop)                   state_d = IDLE;
        else if (do_write && at_top) state_d = IDLE;
      end
      PLAY: begin
        if (stop)                              state_d = IDLE;
        else if (do_emit && at_last && !loop) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs and datapath strobes
  always_comb begin
    enter_rec  = 1'b0;
    enter_play = 1'b0;
    do_write   = 1'b0;
    do_emit    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!stop) begin
          if (rec_start)                            enter_rec  = 1'b1;
          else if (play_start && rec_len_q != '0)  enter_play = 1'b1;
        end
      end
      RECORD:  do_write = tick && !stop;
      PLAY:    do_emit  = tick && !stop;
      default: ;
    endcase
  end

  assign state      = state_q;
  assign beat_tick  = tick;
  assign rec_len    = rec_len_q;
  assign full       = full_q;

  always_ff @(posedge clk) begin
    if (reset || state_q == IDLE || state_d == IDLE || tick) cnt_q <= period_m1;
    else                                                     cnt_q <= cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (do_write) mem[addr_q] <= note_word;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q     <= '0;
      rec_len_q  <= '0;
      full_q     <= 1'b0;
      str_acc_q  <= '0;
      fret_acc_q <= '0;
      note_out   <= '0;
      note_valid <= 1'b0;
    end else begin
      note_valid <= 1'b0;
      if (enter_rec) begin
        addr_q     <= '0;
        rec_len_q  <= '0;
        full_q     <= 1'b0;
        str_acc_q  <= '0;
        fret_acc_q <= '0;
      end else if (enter_play) begin
        addr_q <= '0;
      end else if (state_q == RECORD) begin
        if (stop || do_write) begin
          str_acc_q  <= '0;
          fret_acc_q <= '0;
        end else begin
          str_acc_q  <= str_acc_d;
          fret_acc_q <= fret_acc_d;
        end
        if (do_write) begin
          addr_q    <= addr_q + AW'(1);
          rec_len_q <= {1'b0, addr_q} + (AW+1)'(1);
          if (at_top) full_q <= 1'b1;
        end
      end else if (do_emit) begin
        note_out   <= mem[addr_q];
        note_valid <= 1'b1;
        addr_q     <= at_last ? '0 : addr_q + AW'(1);
      end
    end
  end

endmodule

// File: tb/tb_fretboard_sequencer.sv
// Bench for fretboard_sequencer: table-driven and random beats recorded, then
// replayed against a per-beat reference built from the OR/max note rules.
module tb_fretboard_sequencer;

  localparam int NS = 6;
  localparam int NF = 4;
  localparam int DEP = 4;
  localparam int CW = 27;
  localparam int NW = NS * (NF + 1);

  typedef struct {
    logic [NS-1:0] sa;
    logic [NF-1:0] fa;
    logic [NS-1:0] sb;
    logic [NF-1:0] fb;
    logic [NW-1:0] exp_word;
  } beat_vec_t;

  logic          clk;
  logic          reset;
  logic          rec_start;
  logic          play_start;
  logic          stop;
  logic          loop;
  logic [CW-1:0] beat_period;
  logic [NS-1:0] strings;
  logic [NF-1:0] frets;
  logic [NW-1:0] note_out;
  logic          note_valid;
  logic          beat_tick;
  logic [1:0]    state;
  logic [2:0]    rec_len;
  logic          full;

  int            n_checks;
  int            n_errors;
  logic [NW-1:0] exp_q[$];
  logic [NW-1:0] model_mem [DEP];
  int            model_len;
  beat_vec_t     tab [4];

  fretboard_sequencer #(
    .NUM_STRINGS(NS), .NUM_FRETS(NF), .DEPTH(DEP), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset(reset), .rec_start(rec_start), .play_start(play_start),
    .stop(stop), .loop(loop), .beat_period(beat_period), .strings(strings),
    .frets(frets), .note_out(note_out), .note_valid(note_valid),
    .beat_tick(beat_tick), .state(state), .rec_len(rec_len), .full(full)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int eff_fret(input logic [NF-1:0] f);
    int r;
    r = 0;
    for (int i = 0; i < NF; i++) if (f[i]) r = i + 1;
    return r;
  endfunction

  // Advance one clock; scoreboard any emitted note against the expected queue.
  task automatic step();
    bit tick_b, play_b, stop_b, rst_b;
    logic [NW-1:0] e;
    tick_b = beat_tick;
    play_b = (state == 2'd2);
    stop_b = stop;
    rst_b  = reset;
    @(posedge clk); #1;
    if (!rst_b && (note_valid || (tick_b && play_b && !stop_b))) begin
      check("note_valid", note_valid, tick_b && play_b && !stop_b);
      if (note_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL note_unexpected: got %0h, required no note", note_out);
        end else begin
          e = exp_q.pop_front();
          check("note_out", note_out, e);
        end
      end
    end
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      step();
      n++;
    end
    check("drain_outstanding", exp_q.size(), 0);
    exp_q.delete();
  endtask

  // Drive one beat window (table halves or random) and return the reference word.
  task automatic record_beat(input bit use_tab, input beat_vec_t v, input bit stop_on_tick,
                             output logic [NW-1:0] word);
    logic [NS-1:0] s_or;
    int fr, p;
    bit silent;
    p = (beat_period < 2) ? 2 : int'(beat_period);
    s_or = '0;
    fr = 0;
    silent = ($urandom_range(0, 4) == 0);
    for (int c = 0; c < p; c++) begin
      if (use_tab) begin
        strings = (c < p / 2) ? v.sa : v.sb;
        frets   = (c < p / 2) ? v.fa : v.fb;
      end else begin
        strings = (silent || $urandom_range(0, 2) == 0) ? '0 : NS'($urandom_range(1, 63));
        frets   = NF'($urandom_range(0, 15));
      end
      if (strings != '0) begin
        s_or = s_or | strings;
        if (eff_fret(frets) > fr) fr = eff_fret(frets);
      end
      check("beat_tick", beat_tick, c == p - 1);
      if (c == p - 1 && stop_on_tick) stop = 1'b1;
      step();
      stop = 1'b0;
    end
    strings = '0;
    frets = '0;
    word = NW'(s_or) << (fr * NS);
  endtask

  task automatic play_run(input bit lp, input int n, input bit do_stop);
    for (int i = 0; i < n; i++) exp_q.push_back(model_mem[i % model_len]);
    loop = lp;
    play_start = 1'b1;
    step();
    play_start = 1'b0;
    check("play_state", state, 2);
    wait_drain(n * 12 + 20);
    if (!do_stop) begin
      check("play_end_state", state, 0);
    end else begin
      stop = 1'b1;
      step();
      stop = 1'b0;
      check("stop_play_state", state, 0);
      repeat (15) step();
      check("note_hold", note_out, model_mem[(n - 1) % model_len]);
    end
    repeat (12) step();
    loop = 1'b0;
  endtask

  initial begin
    logic [NW-1:0] w;
    n_checks = 0;
    n_errors = 0;
    reset = 1'b1;
    rec_start = 1'b0;
    play_start = 1'b0;
    stop = 1'b0;
    loop = 1'b0;
    beat_period = CW'(10);
    strings = '0;
    frets = '0;
    model_len = 0;

    tab[0] = '{sa: 6'b000101, fa: 4'b0000, sb: 6'b000001, fb: 4'b0110, exp_word: 30'h0014_0000};
    tab[1] = '{sa: 6'b000000, fa: 4'b0000, sb: 6'b000000, fb: 4'b1111, exp_word: 30'h0000_0000};
    tab[2] = '{sa: 6'b100000, fa: 4'b0001, sb: 6'b000000, fb: 4'b1000, exp_word: 30'h0000_0800};
    tab[3] = '{sa: 6'b000011, fa: 4'b1000, sb: 6'b110000, fb: 4'b0000, exp_word: 30'h3300_0000};

    repeat (2) step();
    reset = 1'b0;
    check("rst_state", state, 0);
    check("rst_note_out", note_out, 0);
    check("rst_note_valid", note_valid, 0);
    check("rst_beat_tick", beat_tick, 0);
    check("rst_rec_len", rec_len, 0);
    check("rst_full", full, 0);

    play_start = 1'b1;
    step();
    play_start = 1'b0;
    check("empty_play_state", state, 0);

    // table-driven record: fills memory
    rec_start = 1'b1;
    play_start = 1'b1;
    step();
    rec_start = 1'b0;
    play_start = 1'b0;
    check("rec_wins_state", state, 1);
    for (int i = 0; i < 4; i++) begin
      record_beat(1'b1, tab[i], 1'b0, w);
      model_mem[i] = tab[i].exp_word;
      check("tab_rec_len", rec_len, i + 1);
    end
    model_len = 4;
    check("full_set", full, 1);
    check("full_state", state, 0);
    play_run(1'b0, 4, 1'b0);

    // random record, partial beat discarded by stop
    rec_start = 1'b1;
    step();
    rec_start = 1'b0;
    check("full_cleared", full, 0);
    check("rerec_state", state, 1);
    check("rerec_len", rec_len, 0);
    for (int i = 0; i < 3; i++) begin
      record_beat(1'b0, tab[0], 1'b0, w);
      model_mem[i] = w;
    end
    repeat (3) begin
      strings = NS'($urandom_range(1, 63));
      frets = NF'($urandom_range(0, 15));
      step();
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    strings = '0;
    frets = '0;
    model_len = 3;
    check("stop_rec_state", state, 0);
    check("stop_rec_len", rec_len, 3);
    check("stop_rec_full", full, 0);
    play_run(1'b0, 3, 1'b0);
    play_run(1'b1, 4, 1'b1);

    // stop coincident with a record tick
    rec_start = 1'b1;
    step();
    rec_start = 1'b0;
    record_beat(1'b0, tab[0], 1'b0, w);
    model_mem[0] = w;
    record_beat(1'b0, tab[0], 1'b1, w);
    model_len = 1;
    check("stop_tick_state", state, 0);
    check("stop_tick_rec_len", rec_len, 1);
    play_run(1'b0, 1, 1'b0);

    // minimum period: ticks every 2 cycles
    beat_period = CW'(1);
    rec_start = 1'b1;
    step();
    rec_start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      record_beat(1'b0, tab[0], 1'b0, w);
      model_mem[i] = w;
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    model_len = 2;
    check("fast_rec_len", rec_len, 2);
    play_run(1'b0, 2, 1'b0);
    beat_period = CW'(10);

    // reset in the middle of looping playback
    exp_q.push_back(model_mem[0]);
    loop = 1'b1;
    play_start = 1'b1;
    step();
    play_start = 1'b0;
    wait_drain(40);
    repeat (3) step();
    reset = 1'b1;
    step();
    check("midrst_state", state, 0);
    check("midrst_note_out", note_out, 0);
    check("midrst_rec_len", rec_len, 0);
    check("midrst_note_valid", note_valid, 0);
    reset = 1'b0;
    loop = 1'b0;
    step();
    play_start = 1'b1;
    step();
    play_start = 1'b0;
    check("post_rst_play_state", state, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fretboard_sequencer.md
Name: fretboard_sequencer

Overview:
- Parametrised record/playback engine for the guitar controller; generalises the fixed 6-string/4-bar, 64-entry recorder.
- Samples string and fret-bar inputs over each beat window and encodes them as a one-hot-per-string note word.
- Stores note words in an internal memory and replays them at the same beat rate, optionally looping.
- Sits between the GPIO input synchroniser and the audio/note-decode stage; driven by the top-level control FSM via start/stop pulses.

Parameters:
NUM_STRINGS, 6, number of string inputs
NUM_FRETS, 4, number of fret-bar inputs (fret 0 = open is implicit)
DEPTH, 64, note memory entries; AW = clog2(DEPTH)
CNT_W, 27, beat counter width
NOTE_W, NUM_STRINGS*(NUM_FRETS+1), derived note word width

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
rec_start  in  1  pulse; begin recording from IDLE
play_start  in  1  pulse; begin playback from IDLE
stop  in  1  pulse; abort current operation
loop  in  1  level; playback wraps to entry 0 after last entry
beat_period  in  CNT_W  clocks per beat
strings  in  NUM_STRINGS  string-plucked inputs, bit s = string s
frets  in  NUM_FRETS  bar-pressed inputs, bit f-1 = fret f
note_out  out  NOTE_W  last played note word
note_valid  out  1  one-cycle pulse when note_out updates
beat_tick  out  1  one-cycle pulse at end of each beat window
state  out  2  0 IDLE, 1 RECORD, 2 PLAY
rec_len  out  AW+1  number of valid recorded entries
full  out  1  recording stopped because memory filled

Behaviour:
- Reset: state=IDLE, note_out=0, note_valid=0, beat_tick=0, rec_len=0, full=0, addr=0, accumulators=0. Memory contents not cleared.
- Beat counter:
  - Effective period P = max(beat_period, 2).
  - In IDLE, held at P-1.
  - Otherwise decrements each clk; beat_tick=1 on the cycle counter==0, then reloads P-1.
  - Entering RECORD/PLAY reloads P-1, so the first tick occurs P cycles after the start pulse.
  - A beat_period change takes effect at the next reload.
- Effective fret for a cycle: highest-numbered asserted frets bit; none asserted = 0 (open).
- Accumulation (RECORD only), every cycle:
  - str_acc |= strings.
  - If strings != 0, fret_acc = max(fret_acc, effective fret).
- Encoding: bit f*NUM_STRINGS+s of the note word is 1 iff string s is set in str_acc and fret_acc == f. All other bits are 0.
- RECORD:
  - Entry from IDLE on rec_start: addr=0, rec_len=0, full=0, accumulators cleared.
  - On a tick cycle, the written word includes that cycle's inputs. mem[addr] <= encoded word; addr++; rec_len <= addr+1; accumulators cleared.
  - Silent beats (str_acc=0) are written as 0.
  - If the write was to entry DEPTH-1: full=1, state goes to IDLE.
  - stop: discard the partial beat, go to IDLE, keep rec_len.
- PLAY:
  - play_start with rec_len==0 is ignored (stays IDLE).
  - Otherwise addr=0 on entry.
  - On tick: memory read of addr. One cycle later note_out <= mem[addr] and note_valid=1 (latency 1 clk after beat_tick).
  - If addr == rec_len-1: with loop=1, addr=0; with loop=0, go to IDLE after emitting.
  - stop: go to IDLE immediately; note_out holds its value.
- Priority and simultaneous events:
  - reset > stop > rec_start > play_start.
  - Start pulses outside IDLE are ignored.
  - rec_start and play_start together in IDLE: record wins.
  - stop on a tick cycle: no write or emission on that tick.
- Reset mid-operation: immediate return to reset values; rec_len=0, so previous memory contents are unreachable.
- full clears only on reset or the next rec_start.

Test Plan (NUM_STRINGS=6, NUM_FRETS=4, DEPTH=4, beat_period=10):
- Beat timing: rec_start at cycle 0 -> beat_tick at cycles 10, 20, 30; beat_period=1 -> ticks every 2 cycles.
- Encoding: within one beat, strings=6'b000101 with frets=4'b0000, then strings=6'b000001 with frets=4'b0110 -> mem[0]=bit 18 | bit 20 (fret 3 row, strings 0 and 2); a beat with no strings -> mem[1]=0.
- Full: record 4 beats -> full=1, rec_len=4, state=IDLE after 4th tick; rec_start again -> full=0.
- Playback: rec_len=3, loop=0, play_start -> note_valid pulses one cycle after each of 3 ticks with mem[0..2], then state=IDLE. With loop=1 -> 4th emission equals mem[0].
- Edge controls:
  - play_start with rec_len=0 -> state stays IDLE.
  - rec_start + play_start together -> RECORD.
  - stop coincident with tick in RECORD -> rec_len unchanged.
- Reset mid-PLAY -> next cycle state=0, note_out=0, rec_len=0, note_valid=0.
